alu_pipe_acc: RTL and testbench
===============================

# alu_pipe_acc

Parametrised, two-stage pipelined ALU with a valid/ready handshake on both sides, an internal accumulator register and a sticky overflow flag. Generalises the combinational 8-bit ALU (add, add-half-B, AND, NOT) to any width, adds accumulate, load and XOR modes, and registers all outputs. It sits between an operand source and a result consumer that may apply backpressure.

## Interface
- SIZE, 8: operand, result and accumulator width in bits (≥ 2).
- Clk  in  1: sole clock; all state updates on the rising edge.
- Reset  in  1: synchronous, active-high; clears all state.
- InValid  in  1: Ain/Bin/Fn/CI valid this cycle.
- InReady  out  1: block accepts an operation this cycle.
- Ain, Bin  in  SIZE: operands, two's complement.
- Fn  in  3: function select (see Operation).
- CI  in  1: carry-in for arithmetic functions.
- ClrSticky  in  1: clears StickyOV.
- OutValid  out  1: Result/CO/OV valid.
- OutReady  in  1: consumer takes the result this cycle.
- Result  out  SIZE: registered result.
- CO, OV  out  1: registered carry-out and signed overflow for the held result.
- StickyOV  out  1: set when any result with OV=1 is presented.
- Acc  out  SIZE: current accumulator value.

## Operation
- Fn codes (X = second adder operand, sum = Ain/Acc + X + CI at SIZE+1 bits, CO = bit SIZE):
  - 000: Ain + Bin + CI.
  - 001: Ain + (Bin >>> 1) + CI; arithmetic shift, sign bit replicated.
  - 010: Ain & Bin.  011: ~Ain.  111: Ain ^ Bin.
  - 100: Acc + Ain + CI; Acc ← Result.
  - 101: Result = Ain; Acc ← Ain.
  - 110: Result = Acc (read, no change).
- OV = (sign of first operand == sign of X) && (sign of Result != that sign); for 000/001/100 only. CO and OV are 0 for all other codes.
- Stage 1 (S1): on accept (InValid && InReady), latch Ain, Bin, Fn, CI; V1 ← 1.
- Stage 2 (S2): on S1→S2 transfer, compute from S1 registers and current Acc; load Result/CO/OV; V2 ← 1; Acc updates on the same edge (Fn 100/101).
- Advance rules: S2 free = !V2 || OutReady. S1→S2 transfer when V1 && S2 free. InReady = !V1 || S2 free (combinational, no bubble at full throughput).
- V1 clears when S1 transfers without a new accept; V2 clears when OutReady && OutValid without a new transfer.
- Result/CO/OV hold stable while OutValid && !OutReady.
- Accumulator dependency: because Acc is read and written only at the S1→S2 edge, back-to-back Fn 100/101/110 operations see the preceding operation's Acc; no stall is needed.
- StickyOV: set on the edge that loads S2 with OV=1; ClrSticky clears it; when both happen on the same edge, set wins.

## Timing
- Reset: V1, V2, OutValid, Result, CO, OV, StickyOV, Acc all 0; InReady = 1 in the cycle after reset.
- Latency: accept at edge N gives OutValid=1 after edge N+1 (2 edges). Throughput is one operation per cycle while OutReady=1.
- Backpressure: with OutReady held 0, the block absorbs two operations (S1, S2). InReady then goes 0 combinationally until OutReady returns.
- Reset asserted mid-operation: both stages are flushed on that edge, in-flight operations are lost, and Acc returns to 0. Inputs are ignored while Reset=1.
- All arithmetic is modulo 2^SIZE; the bit above is CO only.

## Test plan
- SIZE=8, OutReady=1, Fn=000: 0x0F+0xF0 CI=0 → 0xFF CO0 OV0; CI=1 → 0x00 CO1 OV0; 0xFF+0xFF CI=1 → 0xFF CO1 OV0; 0x7F+0x01 → 0x80 CO0 OV1, StickyOV=1 afterwards. Each result appears two edges after accept.
- Fn=001: A=0x80, B=0x36 → 0x9B CO0 OV0; A=0x0F, B=0xF0, CI=1 → 0x08 CO1 OV0.
- Logic functions: 010 with 0xA4,0xB6 → 0xA4; 011 with 0xCF → 0x30; 111 with 0xCF,0xF3 → 0x3C; CO=OV=0 for all three.
- Accumulator, back-to-back over cycles: 101 A=0x10; 100 A=0x05; 100 A=0x03; 110 → Results 0x10, 0x15, 0x18, 0x18; Acc=0x18.
- Backpressure: stream 4 ops with OutReady=0 for 3 cycles. InReady drops after 2 accepts, Result stays stable, and all 4 results emerge in order with no loss or duplication.
- Reset with both stages full and Acc=0x18: the next cycle has OutValid=0, Acc=0, StickyOV=0, InReady=1. ClrSticky on the same edge as a new OV=1 result leaves StickyOV=1.

Source files
------------

// File: rtl/alu_pipe_acc_if.sv
// Operand/result handshake bundle for alu_pipe_acc: source drives operands, consumer drives out_rdy.
interface alu_pipe_acc_if #(
  parameter int SIZE = 8
) ();
  logic            in_vld;
  logic            in_rdy;
  logic [SIZE-1:0] a_dat;
  logic [SIZE-1:0] b_dat;
  logic [2:0]      fn;
  logic            ci;
  logic            clr_sticky;
  logic            out_vld;
  logic            out_rdy;
  logic [SIZE-1:0] res_dat;
  logic            co;
  logic            ov;
  logic            sticky_ov;
  logic [SIZE-1:0] acc_dat;

  modport master (
    output in_vld, a_dat, b_dat, fn, ci, clr_sticky, out_rdy,
    input  in_rdy, out_vld, res_dat, co, ov, sticky_ov, acc_dat
  );

  modport slave (
    input  in_vld, a_dat, b_dat, fn, ci, clr_sticky, out_rdy,
    output in_rdy, out_vld, res_dat, co, ov, sticky_ov, acc_dat
  );
endinterface

// File: rtl/alu_pipe_acc.sv
// Two-stage pipelined ALU with accumulator and sticky overflow; result valid two edges after accept.
// Stages advance only into a free slot, so holding out_rdy low stalls intake after two operations.
module alu_pipe_acc #(
  parameter int SIZE = 8
) (
  input logic           clk_i,
  input logic           rst_i,
  alu_pipe_acc_if.slave bus_io
);
  typedef enum logic [2:0] {
    FN_ADD  = 3'b000,
    FN_ADDH = 3'b001,
    FN_AND  = 3'b010,
    FN_NOT  = 3'b011,
    FN_ACC  = 3'b100,
    FN_LOAD = 3'b101,
    FN_READ = 3'b110,
    FN_XOR  = 3'b111
  } fn_e;

  typedef struct packed {
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    fn_e             fn;
    logic            ci;
  } op_t;

  typedef struct packed {
    logic [SIZE-1:0] res;
    logic            co;
    logic            ov;
  } res_t;

  logic            v1_q, v1_d;
  op_t             s1_q, s1_d;
  logic            v2_q, v2_d;
  res_t            s2_q, s2_d;
  logic [SIZE-1:0] acc_q, acc_d;
  logic            sticky_q, sticky_d;

  logic            s2_free, xfer, in_rdy, accept;
  logic            is_arith;
  logic [SIZE-1:0] opa, opx;
  logic [SIZE:0]   sum;
  res_t            res_n;

  always_comb begin
    s2_free = !v2_q || bus_io.out_rdy;
    xfer    = v1_q && s2_free;
    in_rdy  = (!v1_q || s2_free) && !rst_i;
    accept  = bus_io.in_vld && in_rdy;
  end

  // Acc is read here at the S1->S2 edge, the same edge it is written, so chained acc ops need no stall.
  always_comb begin
    is_arith = (s1_q.fn == FN_ADD) || (s1_q.fn == FN_ADDH) || (s1_q.fn == FN_ACC);
    opa      = (s1_q.fn == FN_ACC) ? acc_q : s1_q.a;
    case (s1_q.fn)
      FN_ADD:  opx = s1_q.b;
      FN_ADDH: opx = {s1_q.b[SIZE-1], s1_q.b[SIZE-1:1]};
      default: opx = s1_q.a;
    endcase
    sum = {1'b0, opa} + {1'b0, opx} + {{SIZE{1'b0}}, s1_q.ci};

    res_n.res = sum[SIZE-1:0];
    case (s1_q.fn)
      FN_AND:  res_n.res = s1_q.a & s1_q.b;
      FN_NOT:  res_n.res = ~s1_q.a;
      FN_XOR:  res_n.res = s1_q.a ^ s1_q.b;
      FN_LOAD: res_n.res = s1_q.a;
      FN_READ: res_n.res = acc_q;
      default: res_n.res = sum[SIZE-1:0];
    endcase
    res_n.co = is_arith && sum[SIZE];
    res_n.ov = is_arith && (opa[SIZE-1] == opx[SIZE-1]) && (sum[SIZE-1] != opa[SIZE-1]);
  end

  always_comb begin
    v1_d = v1_q;
    s1_d = s1_q;
    if (accept) begin
      v1_d = 1'b1;
      s1_d = '{a: bus_io.a_dat, b: bus_io.b_dat, fn: fn_e'(bus_io.fn), ci: bus_io.ci};
    end else if (xfer) begin
      v1_d = 1'b0;
    end

    v2_d = v2_q;
    s2_d = s2_q;
    if (xfer) begin
      v2_d = 1'b1;
      s2_d = res_n;
    end else if (bus_io.out_rdy) begin
      v2_d = 1'b0;
    end

    acc_d = acc_q;
    if (xfer && (s1_q.fn == FN_ACC))  acc_d = sum[SIZE-1:0];
    if (xfer && (s1_q.fn == FN_LOAD)) acc_d = s1_q.a;

    // A fresh overflow outranks a simultaneous clear so no event is lost.
    sticky_d = sticky_q;
    if (bus_io.clr_sticky) sticky_d = 1'b0;
    if (xfer && res_n.ov)  sticky_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q     <= 1'b0;
      s1_q     <= '0;
      v2_q     <= 1'b0;
      s2_q     <= '0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      s1_q     <= s1_d;
      v2_q     <= v2_d;
      s2_q     <= s2_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus_io.in_rdy    = in_rdy;
  assign bus_io.out_vld   = v2_q;
  assign bus_io.res_dat   = s2_q.res;
  assign bus_io.co        = s2_q.co;
  assign bus_io.ov        = s2_q.ov;
  assign bus_io.sticky_ov = sticky_q;
  assign bus_io.acc_dat   = acc_q;
endmodule

// File: tb/tb_alu_pipe_acc.sv
// Directed bench for alu_pipe_acc at SIZE=8: arithmetic, logic, accumulator chaining, backpressure, reset flush.
module tb_alu_pipe_acc;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  alu_pipe_acc_if #(.SIZE(8)) bus ();

  alu_pipe_acc #(.SIZE(8)) u_dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] fn, input logic ci);
    bus.in_vld = 1'b1;
    bus.a_dat  = a;
    bus.b_dat  = b;
    bus.fn     = fn;
    bus.ci     = ci;
  endtask

  // Entered at posedge+1 with an empty pipe; leaves at posedge+1 with the pipe drained.
  task automatic single(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] fn, input logic ci,
                        input logic [7:0] er, input logic eco, input logic eov);
    drive(a, b, fn, ci);
    @(posedge clk); #1 bus.in_vld = 1'b0;
    @(negedge clk);
    chk({tag, ".lat"}, bus.out_vld, 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".vld"}, bus.out_vld, 1);
    chk({tag, ".res"}, bus.res_dat, er);
    chk({tag, ".co"},  bus.co, eco);
    chk({tag, ".ov"},  bus.ov, eov);
    @(posedge clk); #1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    bus.in_vld = 1'b0;
    bus.a_dat = '0;
    bus.b_dat = '0;
    bus.fn = '0;
    bus.ci = 1'b0;
    bus.clr_sticky = 1'b0;
    bus.out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.vld",    bus.out_vld, 0);
    chk("rst.res",    bus.res_dat, 0);
    chk("rst.co",     bus.co, 0);
    chk("rst.ov",     bus.ov, 0);
    chk("rst.sticky", bus.sticky_ov, 0);
    chk("rst.acc",    bus.acc_dat, 0);
    chk("rst.inrdy",  bus.in_rdy, 1);
    @(posedge clk); #1;

    single("add0",  8'h0F, 8'hF0, 3'b000, 1'b0, 8'hFF, 1'b0, 1'b0);
    single("add1",  8'h0F, 8'hF0, 3'b000, 1'b1, 8'h00, 1'b1, 1'b0);
    single("add2",  8'hFF, 8'hFF, 3'b000, 1'b1, 8'hFF, 1'b1, 1'b0);
    chk("sticky.pre", bus.sticky_ov, 0);
    single("addov", 8'h7F, 8'h01, 3'b000, 1'b0, 8'h80, 1'b0, 1'b1);
    chk("sticky.set", bus.sticky_ov, 1);
    single("addh0", 8'h80, 8'h36, 3'b001, 1'b0, 8'h9B, 1'b0, 1'b0);
    single("addh1", 8'h0F, 8'hF0, 3'b001, 1'b1, 8'h08, 1'b1, 1'b0);
    single("and",   8'hA4, 8'hB6, 3'b010, 1'b1, 8'hA4, 1'b0, 1'b0);
    single("not",   8'hCF, 8'h00, 3'b011, 1'b1, 8'h30, 1'b0, 1'b0);
    single("xor",   8'hCF, 8'hF3, 3'b111, 1'b1, 8'h3C, 1'b0, 1'b0);
    chk("sticky.hold", bus.sticky_ov, 1);
    bus.clr_sticky = 1'b1;
    @(posedge clk); #1 bus.clr_sticky = 1'b0;
    chk("sticky.clr", bus.sticky_ov, 0);

    // Accumulator chain, one op per cycle
    drive(8'h10, 8'h00, 3'b101, 1'b0);
    @(posedge clk); #1 drive(8'h05, 8'h00, 3'b100, 1'b0);
    @(posedge clk); #1 drive(8'h03, 8'h00, 3'b100, 1'b0);
    @(negedge clk);
    chk("acc1.res", bus.res_dat, 8'h10);
    chk("acc1.acc", bus.acc_dat, 8'h10);
    @(posedge clk); #1 drive(8'h00, 8'h00, 3'b110, 1'b0);
    @(negedge clk);
    chk("acc2.res", bus.res_dat, 8'h15);
    chk("acc2.acc", bus.acc_dat, 8'h15);
    @(posedge clk); #1 bus.in_vld = 1'b0;
    @(negedge clk);
    chk("acc3.res", bus.res_dat, 8'h18);
    chk("acc3.acc", bus.acc_dat, 8'h18);
    @(posedge clk);
    @(negedge clk);
    chk("acc4.vld", bus.out_vld, 1);
    chk("acc4.res", bus.res_dat, 8'h18);
    chk("acc4.acc", bus.acc_dat, 8'h18);
    @(posedge clk); #1;

    // Backpressure: out_rdy low for three edges
    bus.out_rdy = 1'b0;
    drive(8'h01, 8'h00, 3'b000, 1'b0);
    @(posedge clk); #1 drive(8'h02, 8'h00, 3'b000, 1'b0);
    @(negedge clk);
    chk("bp.rdy1", bus.in_rdy, 1);
    @(posedge clk); #1 drive(8'h03, 8'h00, 3'b000, 1'b0);
    @(negedge clk);
    chk("bp.rdy2", bus.in_rdy, 0);
    chk("bp.vld2", bus.out_vld, 1);
    chk("bp.res2", bus.res_dat, 8'h01);
    @(posedge clk);
    @(negedge clk);
    chk("bp.rdy3", bus.in_rdy, 0);
    chk("bp.res3", bus.res_dat, 8'h01);
    bus.out_rdy = 1'b1;
    #1 chk("bp.rdy_rel", bus.in_rdy, 1);
    @(posedge clk); #1 drive(8'h04, 8'h00, 3'b000, 1'b0);
    @(negedge clk);
    chk("bp.out2", bus.res_dat, 8'h02);
    @(posedge clk); #1 bus.in_vld = 1'b0;
    @(negedge clk);
    chk("bp.out3", bus.res_dat, 8'h03);
    @(posedge clk);
    @(negedge clk);
    chk("bp.vld4", bus.out_vld, 1);
    chk("bp.out4", bus.res_dat, 8'h04);
    @(posedge clk);
    @(negedge clk);
    chk("bp.drain", bus.out_vld, 0);
    @(posedge clk); #1;

    // Reset with both stages full
    bus.out_rdy = 1'b0;
    drive(8'h7F, 8'h01, 3'b000, 1'b0);
    @(posedge clk); #1 drive(8'h01, 8'h01, 3'b000, 1'b0);
    @(posedge clk); #1 drive(8'h55, 8'h00, 3'b101, 1'b0);
    @(negedge clk);
    chk("full.sticky", bus.sticky_ov, 1);
    chk("full.acc",    bus.acc_dat, 8'h18);
    chk("full.inrdy",  bus.in_rdy, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_vld = 1'b0;
    bus.out_rdy = 1'b1;
    @(negedge clk);
    chk("flush.vld",    bus.out_vld, 0);
    chk("flush.acc",    bus.acc_dat, 0);
    chk("flush.sticky", bus.sticky_ov, 0);
    chk("flush.inrdy",  bus.in_rdy, 1);
    chk("flush.res",    bus.res_dat, 0);
    @(posedge clk);
    @(negedge clk);
    chk("flush.vld2", bus.out_vld, 0);
    chk("flush.acc2", bus.acc_dat, 0);
    @(posedge clk); #1;

    // Clear coinciding with a new overflow
    drive(8'h7F, 8'h01, 3'b000, 1'b0);
    @(posedge clk); #1;
    bus.in_vld = 1'b0;
    bus.clr_sticky = 1'b1;
    @(posedge clk); #1 bus.clr_sticky = 1'b0;
    @(negedge clk);
    chk("race.sticky", bus.sticky_ov, 1);
    chk("race.ov",     bus.ov, 1);
    chk("race.res",    bus.res_dat, 8'h80);
    @(posedge clk); #1 bus.clr_sticky = 1'b1;
    @(posedge clk); #1 bus.clr_sticky = 1'b0;
    chk("race.clr", bus.sticky_ov, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
